// File: rtl/and_word_gate.sv
// rtl/and_word_gate.sv - word-wide AND reduction with companion reductions and a registered copy
//
// Ports:
//   clk        rising-edge clock for the registered copy
//   rst        asynchronous active-high reset, clears only the registered outputs
//   in         WIDTH-bit word to evaluate
//   AND_       combinational AND of all bits of in
//   OR_        combinational OR of all bits of in
//   XOR_       combinational XOR (odd parity) of all bits of in
//   zero_cnt   combinational count of 0 bits in in (0..WIDTH)
//   AND_r      AND_ captured on every rising clk edge
//   OR_r       OR_ captured on every rising clk edge
//   zero_cnt_r zero_cnt captured on every rising clk edge

module and_word_gate #(
    parameter int WIDTH = 8,
    parameter int ZCW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic             AND_,
    output logic             OR_,
    output logic             XOR_,
    output logic [ZCW-1:0]   zero_cnt,
    output logic             AND_r,
    output logic             OR_r,
    output logic [ZCW-1:0]   zero_cnt_r
);

    // Reduction operators keep the language's X/Z semantics: a known 0
    // anywhere forces AND_ low no matter what the other bits hold.
    assign AND_ = &in;
    assign OR_  = |in;
    assign XOR_ = ^in;

    always_comb begin
        zero_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            zero_cnt = zero_cnt + ZCW'(!in[i]);
        end
    end

    // Free-running capture: no enable, every edge samples the settled word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AND_r      <= 1'b0;
            OR_r       <= 1'b0;
            zero_cnt_r <= '0;
        end else begin
            AND_r      <= AND_;
            OR_r       <= OR_;
            zero_cnt_r <= zero_cnt;
        end
    end

endmodule

// File: tb/tb_and_word_gate.sv
// tb/tb_and_word_gate.sv - directed and exhaustive checks for and_word_gate
module tb_and_word_gate;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst;
    logic [7:0] in;
    logic       and_o, or_o, xor_o;
    logic [3:0] zc;
    logic       and_r, or_r;
    logic [3:0] zc_r;

    int tests = 0;
    int fails = 0;

    and_word_gate #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .AND_       (and_o),
        .OR_        (or_o),
        .XOR_       (xor_o),
        .zero_cnt   (zc),
        .AND_r      (and_r),
        .OR_r       (or_r),
        .zero_cnt_r (zc_r)
    );

    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        logic [7:0] v;
        logic       e_and;
        logic       e_or;
        logic       e_xor;
        logic [3:0] e_zc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{8'b11111111, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[1]  = '{8'b11111110, 1'b0, 1'b1, 1'b1, 4'd1};
        vecs[2]  = '{8'b11111101, 1'b0, 1'b1, 1'b1, 4'd1};
        vecs[3]  = '{8'b11111011, 1'b0, 1'b1, 1'b1, 4'd1};
        vecs[4]  = '{8'b11110111, 1'b0, 1'b1, 1'b1, 4'd1};
        vecs[5]  = '{8'b11101111, 1'b0, 1'b1, 1'b1, 4'd1};
        vecs[6]  = '{8'b11011111, 1'b0, 1'b1, 1'b1, 4'd1};
        vecs[7]  = '{8'b10111111, 1'b0, 1'b1, 1'b1, 4'd1};
        vecs[8]  = '{8'b01111111, 1'b0, 1'b1, 1'b1, 4'd1};
        vecs[9]  = '{8'b00000000, 1'b0, 1'b0, 1'b0, 4'd8};
        vecs[10] = '{8'b10101010, 1'b0, 1'b1, 1'b0, 4'd4};
        vecs[11] = '{8'b00000001, 1'b0, 1'b1, 1'b1, 4'd7};

        // Reset held, no clock: registered outputs cleared asynchronously.
        rst = 1'b1;
        in  = 8'h00;
        #10;
        check("reset_and_r", 32'(and_r), 32'd0);
        check("reset_or_r",  32'(or_r),  32'd0);
        check("reset_zc_r",  32'(zc_r),  32'd0);

        // Combinational table with the clock stopped.
        for (int i = 0; i < 12; i++) begin
            in = vecs[i].v;
            #10;
            check($sformatf("and_%02h", vecs[i].v), 32'(and_o), 32'(vecs[i].e_and));
            check($sformatf("or_%02h",  vecs[i].v), 32'(or_o),  32'(vecs[i].e_or));
            check($sformatf("xor_%02h", vecs[i].v), 32'(xor_o), 32'(vecs[i].e_xor));
            check($sformatf("zc_%02h",  vecs[i].v), 32'(zc),    32'(vecs[i].e_zc));
        end

        // Load AND_r = 1, then assert reset mid-cycle.
        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in  = 8'hFF;
        @(posedge clk);
        #1;
        check("load_and_r", 32'(and_r), 32'd1);
        check("load_or_r",  32'(or_r),  32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_and_r", 32'(and_r), 32'd0);
        check("async_rst_or_r",  32'(or_r),  32'd0);
        check("async_rst_zc_r",  32'(zc_r),  32'd0);
        check("rst_comb_and",    32'(and_o), 32'd1);

        // Release, capture FF, then 7F shows up only at the following edge.
        @(negedge clk);
        rst = 1'b0;
        in  = 8'hFF;
        #1;
        check("release_wait_and_r", 32'(and_r), 32'd0);
        @(posedge clk);
        #1;
        check("ff_and_r", 32'(and_r), 32'd1);
        check("ff_zc_r",  32'(zc_r),  32'd0);
        @(negedge clk);
        in = 8'h7F;
        #1;
        check("hold_and_r", 32'(and_r), 32'd1);
        check("hold_comb",  32'(and_o), 32'd0);
        @(posedge clk);
        #1;
        check("7f_and_r", 32'(and_r), 32'd0);
        check("7f_or_r",  32'(or_r),  32'd1);
        check("7f_zc_r",  32'(zc_r),  32'd1);
        @(negedge clk);
        in = 8'h00;
        @(posedge clk);
        #1;
        check("00_or_r", 32'(or_r), 32'd0);
        check("00_zc_r", 32'(zc_r), 32'd8);
        clk_run = 1'b0;

        // Exhaustive combinational sweep against a bench-side model.
        for (int v = 0; v < 256; v++) begin
            logic [7:0] w;
            int         zeros;
            w     = 8'(v);
            zeros = 0;
            for (int b = 0; b < 8; b++) if (w[b] == 1'b0) zeros++;
            in = w;
            #1;
            check($sformatf("sw_and_%02h", w), 32'(and_o), 32'(&w));
            check($sformatf("sw_or_%02h",  w), 32'(or_o),  32'(|w));
            check($sformatf("sw_xor_%02h", w), 32'(xor_o), 32'(^w));
            check($sformatf("sw_zc_%02h",  w), 32'(zc),    32'(zeros));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
